// File: rtl/lteq_running_min_reducer.sv
// lteq_running_min_reducer
// Framed stream reducer: tracks the unsigned minimum of each frame (latest beat
// wins on ties), its beat index and the saturating beat count, then holds the
// result until downstream takes it.
module lteq_running_min_reducer #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W-1:0] out_count,
    output logic             out_sat
);

    localparam logic [1:0] FIRST = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [IDX_W-1:0] CNT_MAX = '1;

    logic [1:0]       state;
    logic             accept;
    logic             take;
    logic             cnt_full;

    // Running accumulator for the frame in progress; acc_cnt doubles as the
    // position of the next beat since both advance together and saturate alike.
    logic [WIDTH-1:0] acc_min;
    logic [IDX_W-1:0] acc_idx;
    logic [IDX_W-1:0] acc_cnt;
    logic             acc_sat;

    logic [WIDTH-1:0] nxt_min;
    logic [IDX_W-1:0] nxt_idx;
    logic [IDX_W-1:0] nxt_cnt;
    logic             nxt_sat;

    // Handshake flags depend on registered state only.
    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;
    assign take      = (in_data <= acc_min);
    assign cnt_full  = (acc_cnt == CNT_MAX);

    // Accumulator value after absorbing the current beat.
    always_comb begin
        nxt_min = acc_min;
        nxt_idx = acc_idx;
        nxt_cnt = acc_cnt;
        nxt_sat = acc_sat;
        if (state == FIRST) begin
            nxt_min = in_data;
            nxt_idx = '0;
            nxt_cnt = IDX_W'(1);
            nxt_sat = 1'b0;
        end else begin
            if (take) begin
                nxt_min = in_data;
                nxt_idx = acc_cnt;
            end
            if (!cnt_full) begin
                nxt_cnt = acc_cnt + 1'b1;
            end
            nxt_sat = acc_sat | cnt_full;
        end
    end

    // Frame sequencing, accumulator update and result capture on the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FIRST;
            acc_min   <= '0;
            acc_idx   <= '0;
            acc_cnt   <= '0;
            acc_sat   <= 1'b0;
            out_min   <= '0;
            out_idx   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else if (accept) begin
            acc_min <= nxt_min;
            acc_idx <= nxt_idx;
            acc_cnt <= nxt_cnt;
            acc_sat <= nxt_sat;
            if (in_last) begin
                out_min   <= nxt_min;
                out_idx   <= nxt_idx;
                out_count <= nxt_cnt;
                out_sat   <= nxt_sat;
                state     <= HOLD;
            end else begin
                state <= ACCUM;
            end
        end else if (state == HOLD && out_ready) begin
            state <= FIRST;
        end
    end

endmodule

// File: tb/tb_lteq_running_min_reducer.sv
// Testbench for lteq_running_min_reducer: two instances (IDX_W=8 and IDX_W=4)
// share one stimulus stream and are compared every cycle against a frame-level
// reference model; directed frames pin the model with literal expectations.
module tb_lteq_running_min_reducer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_data = '0;

    logic        a_rdy, a_ov, a_sat;
    logic [31:0] a_min;
    logic [7:0]  a_idx, a_cnt;
    logic        b_rdy, b_ov, b_sat;
    logic [31:0] b_min;
    logic [3:0]  b_idx, b_cnt;

    int errors = 0;
    int checks = 0;
    bit rand_or = 0;

    always #5 clk = ~clk;

    lteq_running_min_reducer #(.WIDTH(32), .IDX_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy),
        .in_data(in_data), .in_last(in_last), .out_valid(a_ov),
        .out_ready(out_ready), .out_min(a_min), .out_idx(a_idx),
        .out_count(a_cnt), .out_sat(a_sat)
    );

    lteq_running_min_reducer #(.WIDTH(32), .IDX_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_rdy),
        .in_data(in_data), .in_last(in_last), .out_valid(b_ov),
        .out_ready(out_ready), .out_min(b_min), .out_idx(b_idx),
        .out_count(b_cnt), .out_sat(b_sat)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] q[$];
    bit          exp_valid = 0;
    bit          started = 0;
    logic [31:0] ea_min = '0, eb_min = '0;
    int unsigned ea_idx = 0, ea_cnt = 0, eb_idx = 0, eb_cnt = 0;
    bit          ea_sat = 0, eb_sat = 0;

    // Result of a whole frame: minimum (latest on ties), its index clipped to
    // maxv, beat count clipped to maxv, and overflow flag.
    task automatic calc(input int unsigned maxv, output logic [31:0] m,
                        output int unsigned ix, output int unsigned cn, output bit st);
        m  = q[0];
        ix = 0;
        for (int i = 1; i < q.size(); i++) begin
            if (q[i] <= m) begin
                m  = q[i];
                ix = i;
            end
        end
        if (ix > maxv) ix = maxv;
        cn = (q.size() > maxv) ? maxv : q.size();
        st = (q.size() > maxv);
    endtask

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            q.delete();
            exp_valid = 0;
            ea_min = '0; ea_idx = 0; ea_cnt = 0; ea_sat = 0;
            eb_min = '0; eb_idx = 0; eb_cnt = 0; eb_sat = 0;
        end else if (exp_valid) begin
            if (out_ready) exp_valid = 0;
        end else if (in_valid) begin
            q.push_back(in_data);
            if (in_last) begin
                calc(255, ea_min, ea_idx, ea_cnt, ea_sat);
                calc(15, eb_min, eb_idx, eb_cnt, eb_sat);
                exp_valid = 1;
                q.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("a_in_ready", a_rdy, !exp_valid);
            chk("a_out_valid", a_ov, exp_valid);
            chk("a_out_min", a_min, ea_min);
            chk("a_out_idx", a_idx, ea_idx);
            chk("a_out_count", a_cnt, ea_cnt);
            chk("a_out_sat", a_sat, ea_sat);
            chk("b_in_ready", b_rdy, !exp_valid);
            chk("b_out_valid", b_ov, exp_valid);
            chk("b_out_min", b_min, eb_min);
            chk("b_out_idx", b_idx, eb_idx);
            chk("b_out_count", b_cnt, eb_cnt);
            chk("b_out_sat", b_sat, eb_sat);
        end
    end

    // ---------------- stimulus ----------------
    always @(posedge clk) begin
        if (rand_or) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic beat(input logic [31:0] d, input bit last);
        int n;
        bit acc;
        n   = 0;
        acc = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!acc) begin
            @(negedge clk);
            acc = a_rdy;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 200) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout: in_ready stayed %0b, required 1", a_rdy);
                acc = 1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_data  = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 7));
            1: return 32'h0000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000 ^ 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int n;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", a_ov, 0);
        chk("rst_in_ready", a_rdy, 1);
        chk("rst_out_min", a_min, 0);
        chk("rst_out_count", a_cnt, 0);

        // Frame [5,3,9,3]: tie picks the later 3.
        beat(5, 0); beat(3, 0); beat(9, 0); beat(3, 1);
        chk("t1_valid", a_ov, 1);
        chk("t1_min", a_min, 3);
        chk("t1_idx", a_idx, 3);
        chk("t1_count", a_cnt, 4);
        chk("t1_sat", a_sat, 0);

        // Single-beat frame at the top of the range.
        beat(32'hFFFF_FFFF, 1);
        chk("t2_min", a_min, 32'hFFFF_FFFF);
        chk("t2_idx", a_idx, 0);
        chk("t2_count", a_cnt, 1);

        // Backpressure on the result.
        beat(10, 0);
        out_ready = 1'b0;
        beat(20, 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("t3_hold_in_ready", a_rdy, 0);
            chk("t3_hold_valid", a_ov, 1);
            chk("t3_hold_min", a_min, 10);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_after_in_ready", a_rdy, 1);
        chk("t3_after_valid", a_ov, 0);
        chk("t3_after_min_held", a_min, 10);
        beat(7, 0); beat(0, 1);
        chk("t3_min", a_min, 0);
        chk("t3_idx", a_idx, 1);

        // 20 descending beats: saturates the IDX_W=4 instance.
        for (int i = 20; i >= 1; i--) beat(32'(i), i == 1);
        chk("t4_b_count", b_cnt, 15);
        chk("t4_b_idx", b_idx, 15);
        chk("t4_b_min", b_min, 1);
        chk("t4_b_sat", b_sat, 1);
        chk("t4_a_count", a_cnt, 20);
        chk("t4_a_idx", a_idx, 19);
        chk("t4_a_sat", a_sat, 0);

        // Reset mid-frame discards the partial frame.
        beat(4, 0); beat(2, 0);
        pulse_rst();
        chk("t5_rst_valid", a_ov, 0);
        chk("t5_rst_min", a_min, 0);
        chk("t5_rst_count", a_cnt, 0);
        chk("t5_rst_in_ready", a_rdy, 1);
        beat(8, 0); beat(6, 1);
        chk("t5_min", a_min, 6);
        chk("t5_idx", a_idx, 1);
        chk("t5_count", a_cnt, 2);

        // Unsigned compare across the sign bit, with holes.
        beat(32'h8000_0000, 0);
        idle(3);
        beat(32'h7FFF_FFFF, 1);
        chk("t6_min", a_min, 32'h7FFF_FFFF);
        chk("t6_idx", a_idx, 1);

        // Randomized frames, holes, backpressure and occasional resets.
        rand_or = 1;
        for (int f = 0; f < 300; f++) begin
            len = $urandom_range(1, 25);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                beat(rv(), k == len - 1);
                if (k < len - 1 && $urandom_range(0, 199) == 0) begin
                    pulse_rst();
                    k = len;
                end
            end
        end
        rand_or = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        n = 0;
        while (a_ov && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_valid", a_ov, 0);
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
